// File: rtl/csa_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csa_accum_pkg
// Description : Shared state encoding and width helper for the carry-save
//               multi-operand accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package csa_accum_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Two operands per beat, so the headroom covers 2*MAX_BEATS addends.
    function automatic int acc_width(input int width, input int max_beats);
        return width + $clog2(2 * max_beats);
    endfunction

endpackage
`default_nettype wire

// File: rtl/compressor_4_2.sv
`default_nettype none
// ============================================================================
// Module      : compressor_4_2
// Description : Single-bit 4:2 compressor built from two chained full adders.
// Revision    : 1.0 - initial release
// ============================================================================
module compressor_4_2 (
    input  logic a1,
    input  logic a2,
    input  logic a3,
    input  logic a4,
    input  logic cin,
    output logic sum,
    output logic carry,
    output logic cout
);

    logic w_s1;

    // cout depends only on a1..a3, so the row has no ripple path through cin.
    assign w_s1  = a1 ^ a2 ^ a3;
    assign cout  = (a1 & a2) | (a1 & a3) | (a2 & a3);
    assign sum   = w_s1 ^ a4 ^ cin;
    assign carry = (w_s1 & a4) | (w_s1 & cin) | (a4 & cin);

endmodule
`default_nettype wire

// File: rtl/compressor_row.sv
`default_nettype none
// ============================================================================
// Module      : compressor_row
// Description : W-bit row of 4:2 compressors with cout->cin chaining between
//               neighbouring bits; purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module compressor_row #(
    parameter int W = 20
) (
    input  logic [W-1:0] a1,
    input  logic [W-1:0] a2,
    input  logic [W-1:0] a3,
    input  logic [W-1:0] a4,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    logic [W-1:0] w_cout;
    logic [W-1:0] w_cin;
    logic         w_unused_cout_top;

    assign w_cin[0]          = 1'b0;
    assign w_unused_cout_top = w_cout[W-1];

    generate
        for (genvar i = 0; i < W; i++) begin : g_bit
            if (i > 0) begin : g_chain
                assign w_cin[i] = w_cout[i-1];
            end
            compressor_4_2 u_cmp (
                .a1    (a1[i]),
                .a2    (a2[i]),
                .a3    (a3[i]),
                .a4    (a4[i]),
                .cin   (w_cin[i]),
                .sum   (sum[i]),
                .carry (carry[i]),
                .cout  (w_cout[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/csa_accum_seq.sv
`default_nettype none
// ============================================================================
// Module      : csa_accum_seq
// Description : Sequential carry-save accumulator: one compressor row per beat,
//               one carry-propagate resolve cycle, valid/ready result.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_accum_seq
    import csa_accum_pkg::*;
#(
    parameter  int WIDTH     = 16,
    parameter  int MAX_BEATS = 8,
    localparam int ACC_W     = acc_width(WIDTH, MAX_BEATS),
    localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_err
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_sum_q;
    logic [ACC_W-1:0]   r_carry_q;
    logic [CNT_W-1:0]   r_count;
    logic               r_err_pend;
    logic [ACC_W-1:0]   w_row_s_in;
    logic [ACC_W-1:0]   w_row_c_in;
    logic [ACC_W-1:0]   w_a_ext;
    logic [ACC_W-1:0]   w_b_ext;
    logic [ACC_W-1:0]   w_row_sum;
    logic [ACC_W-1:0]   w_row_carry;
    logic               w_unused_carry_top;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               w_accept;
    logic               w_at_limit;
    logic               w_last;

    assign in_ready    = (r_state == IDLE) || (r_state == ACCUM);
    assign w_accept    = in_valid & in_ready;
    assign w_a_ext     = {{(ACC_W-WIDTH){1'b0}}, in_a};
    assign w_b_ext     = {{(ACC_W-WIDTH){1'b0}}, in_b};

    // A fresh accumulation starts from zero rather than clearing state on exit.
    assign w_row_s_in  = (r_state == IDLE) ? '0 : r_sum_q;
    assign w_row_c_in  = (r_state == IDLE) ? '0 : r_carry_q;
    assign w_count_nxt = (r_state == IDLE) ? CNT_W'(1) : r_count + CNT_W'(1);
    assign w_at_limit  = (w_count_nxt == CNT_W'(MAX_BEATS));
    assign w_last      = in_last | w_at_limit;

    assign w_unused_carry_top = w_row_carry[ACC_W-1];

    compressor_row #(.W(ACC_W)) u_row (
        .a1    (w_row_s_in),
        .a2    (w_row_c_in),
        .a3    (w_a_ext),
        .a4    (w_b_ext),
        .sum   (w_row_sum),
        .carry (w_row_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, ACCUM: begin
                if (w_accept) begin
                    w_state_nxt = w_last ? RESOLVE : ACCUM;
                end
            end
            RESOLVE: w_state_nxt = DONE;
            DONE: begin
                if (out_valid && out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum_q    <= '0;
            r_carry_q  <= '0;
            r_count    <= '0;
            r_err_pend <= 1'b0;
            out_sum    <= '0;
            out_beats  <= '0;
            out_err    <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sum_q    <= w_row_sum;
                r_carry_q  <= {w_row_carry[ACC_W-2:0], 1'b0};
                r_count    <= w_count_nxt;
                r_err_pend <= w_at_limit & ~in_last;
            end
            if (r_state == RESOLVE) begin
                out_sum   <= r_sum_q + r_carry_q;
                out_beats <= r_count;
                out_err   <= r_err_pend;
                out_valid <= 1'b1;
            end else if ((r_state == DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csa_accum_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_csa_accum_seq
// Description : Self-checking bench for csa_accum_seq: transaction-level
//               model compared every cycle plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csa_accum_seq;

    localparam int WIDTH     = 16;
    localparam int MAX_BEATS = 8;
    localparam int ACC_W     = 20;
    localparam int CNT_W     = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_beats;
    logic             out_err;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    csa_accum_seq #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_beats (out_beats),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: running integer total of accepted operands.
    bit     m_ready = 1'b1;
    bit     m_resolve = 1'b0;
    bit     m_ovalid = 1'b0;
    bit     m_errp = 1'b0;
    int     m_cnt = 0;
    longint m_total = 0;
    longint m_osum = 0;
    int     m_obeats = 0;
    bit     m_oerr = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_ready   <= 1'b1;
            m_resolve <= 1'b0;
            m_ovalid  <= 1'b0;
            m_errp    <= 1'b0;
            m_cnt     <= 0;
            m_total   <= 0;
            m_osum    <= 0;
            m_obeats  <= 0;
            m_oerr    <= 1'b0;
        end else if (m_ovalid) begin
            if (out_ready) begin
                m_ovalid <= 1'b0;
                m_ready  <= 1'b1;
                m_cnt    <= 0;
            end
        end else if (m_resolve) begin
            m_osum    <= m_total % (longint'(1) << ACC_W);
            m_obeats  <= m_cnt;
            m_oerr    <= m_errp;
            m_ovalid  <= 1'b1;
            m_resolve <= 1'b0;
        end else if (m_ready && in_valid) begin
            m_total <= ((m_cnt == 0) ? longint'(0) : m_total) + longint'(in_a) + longint'(in_b);
            m_cnt   <= m_cnt + 1;
            if (in_last || (m_cnt + 1 == MAX_BEATS)) begin
                m_ready   <= 1'b0;
                m_resolve <= 1'b1;
                m_errp    <= !in_last;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_in_ready", in_ready, m_ready);
            chk("cyc_out_valid", out_valid, m_ovalid);
            if (m_ovalid) begin
                chk("cyc_out_sum", out_sum, m_osum);
                chk("cyc_out_beats", out_beats, m_obeats);
                chk("cyc_out_err", out_err, m_oerr);
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic last);
        int n = 0;
        @(negedge clk);
        in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", n, 0);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0; in_last = 1'b0;
        end
    endtask

    task automatic get_result(input longint es, input int eb, input bit ee, input int hold);
        int k;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        k = 1;
        chk("ready_after_last", in_ready, 0);
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("latency", k, 2);
        chk("res_sum", out_sum, es);
        chk("res_beats", out_beats, eb);
        chk("res_err", out_err, ee);
        chk("model_sum", m_osum, es);
        chk("model_beats", m_obeats, eb);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", out_sum, es);
            chk("hold_beats", out_beats, eb);
            chk("hold_err", out_err, ee);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_beats", out_beats, 0);
        chk("rst_out_err", out_err, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        send(16'd3, 16'd5, 1'b1);
        get_result(8, 1, 1'b0, 0);

        for (int i = 0; i < 4; i++) send(16'hFFFF, 16'hFFFF, i == 3);
        get_result(524280, 4, 1'b0, 0);

        for (int i = 0; i < 8; i++) send(16'd1, 16'd1, 1'b0);
        get_result(16, 8, 1'b1, 5);

        send(16'd100, 16'd200, 1'b0);
        send(16'd100, 16'd200, 1'b0);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_a = 16'd50; in_b = 16'd50; in_last = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        send(16'd7, 16'd9, 1'b1);
        get_result(16, 1, 1'b0, 0);

        send(16'd1, 16'd2, 1'b0);
        idle(3);
        chk("bubble_in_ready", in_ready, 1);
        chk("bubble_out_valid", out_valid, 0);
        send(16'd3, 16'd4, 1'b1);
        get_result(10, 2, 1'b0, 0);

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/csa_accum_seq.md
Name: csa_accum_seq

Overview:
- Sequential multi-operand accumulator built around one row of 4:2 compressors.
- Each accepted beat carries two unsigned operands. The row compresses them together with the carry-save state (sum vector, carry vector) into a new carry-save state.
- After the last beat, one resolve cycle performs the carry-propagate add, and the result is presented on a valid/ready output.
- Used by the multiplier team for partial-product and dot-product reduction where a full Dadda tree is too large.

Parameters:
- WIDTH, 16, width of each input operand.
- MAX_BEATS, 8, maximum beats per accumulation; must be >= 1.
- ACC_W, WIDTH+$clog2(2*MAX_BEATS), accumulator/result width (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat.
- in_a  input  WIDTH  operand A, unsigned.
- in_b  input  WIDTH  operand B, unsigned.
- in_last  input  1  marks final beat of the accumulation.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  ACC_W  resolved sum of all operands, modulo 2^ACC_W.
- out_beats  output  $clog2(MAX_BEATS+1)  number of beats accumulated.
- out_err  output  1  beat limit reached without in_last.

Behaviour:
- Interface decision: one clock domain (clk); rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: state=IDLE, sum_q=0, carry_q=0, beat count=0, in_ready=1, out_valid=0, out_sum=0, out_beats=0, out_err=0.
- States:
  - IDLE: in_ready=1. Accepting a beat (in_valid & in_ready) uses zero for the accumulator inputs, loads the compressor row output, and sets count=1. Go to ACCUM, or to RESOLVE if the beat is last.
  - ACCUM: in_ready=1. An accepted beat compresses {sum_q, carry_q, in_a, in_b}, count+1. Go to RESOLVE if the beat is last.
  - RESOLVE: in_ready=0. Register out_sum = sum_q + carry_q (ACC_W bits, truncated), latch out_beats and out_err, set out_valid=1. Go to DONE.
  - DONE: in_ready=0; out_sum, out_beats and out_err are held stable. On out_valid & out_ready: clear out_valid and go to IDLE. No input is accepted in the same cycle.
- A beat is last when in_last=1, or when it is the MAX_BEATS-th beat. In the second case with in_last=0, out_err=1.
- No beat is accepted in a cycle where in_valid=0 (bubble): state, count and accumulators are unchanged.
- Latency: last beat accepted at cycle t → out_valid high from cycle t+2.
- Throughput: one accumulation per (beats + 2 + handshake) cycles; no overlap.
- Arithmetic:
  - Operands are zero-extended to ACC_W.
  - Row bit i: a1=sum_q[i], a2=carry_q[i], a3=in_a[i], a4=in_b[i], cin=cout[i-1] (cin[0]=0).
  - New sum_q[i] = sum[i]. New carry_q = {carry[ACC_W-2:0], 0} (weight-2 shift). The top cout and top carry bit are dropped (mod 2^ACC_W).
- Invariant: sum_q + carry_q (mod 2^ACC_W) equals the running total of accepted operands at all times.
- Reset mid-operation: rst in any state returns to the reset values on the next edge; partial state is discarded. A beat presented in the reset cycle is not accepted.
- out_ready while out_valid=0 is ignored.

Decomposition:
- Package csa_accum_pkg:
  - state enum {IDLE, ACCUM, RESOLVE, DONE}.
  - function computing ACC_W from WIDTH and MAX_BEATS.
- Sub-module compressor_row #(W): W instances of the existing compressor_4_2 with cout→cin chaining; outputs sum[W-1:0] and carry[W-1:0]; purely combinational.
- The controller FSM, counters and CPA stay in csa_accum_seq.

Test Plan:
- Single beat, WIDTH=16: a=3, b=5, last=1 → out_valid 2 cycles after accept; out_sum=8, out_beats=1, out_err=0.
- 4 beats of a=b=0xFFFF, last on beat 4 → out_sum=0x7FFF8 (524280), out_beats=4, out_err=0.
- 8 beats of a=b=1 with in_last always 0 → 8th beat is forced last; out_sum=16, out_beats=8, out_err=1; in_ready=0 from the cycle after beat 8.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_sum, out_beats and out_err stable; in_ready=0 throughout. Raise out_ready → out_valid=0 and in_ready=1 next cycle.
- Reset after 2 accepted beats (a=100, b=200 each), then one beat a=7, b=9, last → out_sum=16, out_beats=1; no residue from before the reset.
- Beats a=1/b=2, bubble of 3 cycles, a=3/b=4 last → out_sum=10, out_beats=2; bubbles change nothing.
